alu_muldiv: RTL and testbench



---
 rtl/alu_muldiv_if.sv | 26 ++
 rtl/alu_muldiv.sv | 174 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Handshake bundle for the execute-stage ALU with iterative mul/div.
// Producer drives operands in; consumer takes the registered result out.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [3:0]       ALUctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             EQ;
  logic             busy;

  modport master (
    output in_valid, d0, d1, ALUctrl, out_ready,
    input  in_ready, out_valid, dout, EQ, busy
  );

  modport slave (
    input  in_valid, d0, d1, ALUctrl, out_ready,
    output in_ready, out_valid, dout, EQ, busy
  );
endinterface

// File: rtl/alu_muldiv.sv
// Registered ALU with shift-add multiply and restoring divide.
// One op in flight; result held until the consumer takes it.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_muldiv_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               eq_q, eq_d;

  logic [WIDTH-1:0]   alu_res;
  logic [SHW-1:0]     sh;
  logic               in_iter;
  logic               is_mul;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   shifted;
  logic               ge;
  logic [WIDTH:0]     r_next;
  logic [WIDTH-1:0]   q_next;
  logic [WIDTH-1:0]   it_res;

  assign sh      = bus.d1[SHW-1:0];
  assign in_iter = (bus.ALUctrl >= OP_MUL) && (bus.ALUctrl <= 4'b1101);
  assign is_mul  = (op_q == OP_MUL) || (op_q == OP_MULHU);

  always_comb begin
    alu_res = '0;
    unique case (bus.ALUctrl)
      OP_ADD:  alu_res = bus.d0 + bus.d1;
      OP_SUB:  alu_res = bus.d0 - bus.d1;
      OP_AND:  alu_res = bus.d0 & bus.d1;
      OP_OR:   alu_res = bus.d0 | bus.d1;
      OP_XOR:  alu_res = bus.d0 ^ bus.d1;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(bus.d0) < $signed(bus.d1)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.d0 < bus.d1};
      OP_SLL:  alu_res = bus.d0 << sh;
      OP_SRL:  alu_res = bus.d0 >> sh;
      OP_SRA:  alu_res = $unsigned($signed(bus.d0) >>> sh);
      default: alu_res = '0;
    endcase
  end

  // Multiplier sits in acc low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Dividend shifts out of acc low half; quotient bits shift in behind it.
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign ge      = shifted >= {2'b00, b_q};
  assign r_next  = ge ? (shifted[WIDTH:0] - {1'b0, b_q})
                      : shifted[WIDTH:0];
  assign q_next  = {acc_q[WIDTH-2:0], ge};

  always_comb begin
    it_res = '0;
    unique case (op_q)
      OP_MUL:   it_res = mul_next[WIDTH-1:0];
      OP_MULHU: it_res = mul_next[2*WIDTH-1:WIDTH];
      OP_DIVU:  it_res = q_next;
      default:  it_res = r_next[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    eq_d    = eq_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d  = bus.d0;
          b_d  = bus.d1;
          op_d = bus.ALUctrl;
          eq_d = (bus.d0 == bus.d1);
          if (in_iter) begin
            state_d = BUSY;
            cnt_d   = (SHW+1)'(WIDTH);
            rem_d   = '0;
            acc_d   = {{WIDTH{1'b0}},
                       (bus.ALUctrl[2] ? bus.d0 : bus.d1)};
          end else begin
            state_d = DONE;
            dout_d  = alu_res;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (is_mul) begin
          acc_d = mul_next;
        end else begin
          acc_d = {{WIDTH{1'b0}}, q_next};
          rem_d = r_next;
        end
        if (cnt_q == 1) begin
          state_d = DONE;
          dout_d  = it_res;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      eq_q    <= eq_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.dout      = dout_q;
  assign bus.EQ        = eq_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: op results, latency,
// backpressure and mid-operation reset.
module tb_alu_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(W)) bus();

  alu_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         eq;
  } vec_t;

  vec_t vecs [20] = '{
    '{4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0},
    '{4'h1, 32'h5,        32'h5,        32'h0,        1'b1},
    '{4'h5, 32'h80000000, 32'h1,        32'h1,        1'b0},
    '{4'h6, 32'h80000000, 32'h1,        32'h0,        1'b0},
    '{4'h9, 32'h80000000, 32'h21,       32'hC0000000, 1'b0},
    '{4'h2, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0},
    '{4'h3, 32'hF0F0,     32'h0F0F,     32'hFFFF,     1'b0},
    '{4'h4, 32'hFF,       32'hF0,       32'h0F,       1'b0},
    '{4'h7, 32'h1,        32'h3F,       32'h80000000, 1'b0},
    '{4'h8, 32'h80000000, 32'h4,        32'h08000000, 1'b0},
    '{4'h1, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0},
    '{4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b1},
    '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1},
    '{4'hA, 32'h7,        32'h6,        32'd42,       1'b0},
    '{4'hB, 32'h10000,    32'h10000,    32'h1,        1'b1},
    '{4'hC, 32'd100,      32'd7,        32'd14,       1'b0},
    '{4'hD, 32'd100,      32'd7,        32'd2,        1'b0},
    '{4'hC, 32'h1234,     32'h0,        32'hFFFFFFFF, 1'b0},
    '{4'hD, 32'h1234,     32'h0,        32'h1234,     1'b0},
    '{4'hE, 32'h3,        32'h3,        32'h0,        1'b1}
  };

  task automatic issue(input logic [3:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output int lat,
                       output int nbusy,
                       output int nrdy);
    int guard;
    lat = 0;
    nbusy = 0;
    nrdy = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.d0 = a;
    bus.d1 = b;
    bus.ALUctrl = op;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.d0 = ~a;
    bus.d1 = ~b;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) nbusy++;
      if (bus.in_ready) nrdy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("retire_ovalid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int lat, nb, nr;
    logic iter;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.d0 = '0;
    bus.d1 = '0;
    bus.ALUctrl = '0;

    #23;
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_eq", 64'(bus.EQ), 64'd0);
    check("rst_ovalid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_iready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      iter = (vecs[i].op >= 4'hA) && (vecs[i].op <= 4'hD);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, nb, nr);
      check($sformatf("v%0d_dout", i), 64'(bus.dout), 64'(vecs[i].r));
      check($sformatf("v%0d_eq", i), 64'(bus.EQ), 64'(vecs[i].eq));
      check($sformatf("v%0d_lat", i), 64'(lat),
            iter ? 64'd33 : 64'd1);
      if (iter) begin
        check($sformatf("v%0d_busy", i), 64'(nb), 64'd32);
        check($sformatf("v%0d_irdy", i), 64'(nr), 64'd0);
      end
      retire();
    end

    // Backpressure with a pending request queued behind the result.
    issue(4'h0, 32'd10, 32'd20, lat, nb, nr);
    check("bp_first", 64'(bus.dout), 64'd30);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUctrl = 4'h4;
    bus.d0 = 32'hFF;
    bus.d1 = 32'hF0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("bp_ovalid", 64'(bus.out_valid), 64'd1);
      check("bp_dout", 64'(bus.dout), 64'd30);
      check("bp_iready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_idle_ovalid", 64'(bus.out_valid), 64'd0);
    check("bp_idle_iready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_pend_ovalid", 64'(bus.out_valid), 64'd1);
    check("bp_pend_dout", 64'(bus.dout), 64'h0F);
    retire();

    // Reset partway through a divide.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUctrl = 4'hC;
    bus.d0 = 32'd1000;
    bus.d1 = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_ovalid", 64'(bus.out_valid), 64'd0);
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_dout", 64'(bus.dout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_iready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) check("mid_stale", 64'd1, 64'd0);
    end
    issue(4'h0, 32'd2, 32'd3, lat, nb, nr);
    check("post_add", 64'(bus.dout), 64'd5);
    check("post_lat", 64'(lat), 64'd1);
    retire();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
